// File: rtl/m1_lane_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : m1_lane_dispatcher
// Description : Round-robin dispatcher sharing two M1-style worker lanes
//               between NUM_REQ requesters. Each lane issues a one-cycle
//               start pulse, waits for done or a timeout, then returns a
//               one-cycle response tagged with the requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module m1_lane_dispatcher #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*4-1:0]   req_data,
  input  logic [NUM_REQ*8-1:0]   req_cfg,
  output logic [7:0]             w0_C,
  output logic                   w0_x0,
  output logic [3:0]             w0_x1,
  input  logic                   w0_x2,
  output logic [7:0]             w1_C,
  output logic                   w1_x0,
  output logic [3:0]             w1_x1,
  input  logic                   w1_x2,
  output logic                   rsp0_valid,
  output logic [2:0]             rsp0_id,
  output logic                   rsp0_err,
  output logic                   rsp1_valid,
  output logic [2:0]             rsp1_id,
  output logic                   rsp1_err,
  output logic                   busy
);

  localparam logic [2:0] c_LAST    = 3'(NUM_REQ - 1);
  localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } lane_state_t;

  lane_state_t r_state     [2];
  lane_state_t w_state_nxt [2];
  logic [7:0]  r_cnt       [2];
  logic [7:0]  w_cnt_nxt   [2];
  logic        r_rsp_valid [2];
  logic        r_rsp_err   [2];
  logic        w_rsp_valid_nxt [2];
  logic        w_rsp_err_nxt   [2];
  logic [7:0]  r_cfg       [2];
  logic [3:0]  r_data      [2];
  logic [2:0]  r_id        [2];
  logic [2:0]  w_acc_idx   [2];

  logic [1:0]  w_free;
  logic [1:0]  w_done;
  logic [1:0]  w_accept;
  logic [2:0]  r_ptr;
  logic [2:0]  w_ptr_nxt;
  logic [7:0]  w_valid_ext;
  logic [31:0] w_data_ext;
  logic [63:0] w_cfg_ext;
  logic        w_g1_found;
  logic        w_g2_found;
  logic [2:0]  w_g1_idx;
  logic [2:0]  w_g2_idx;
  logic        w_grant1;
  logic        w_grant2;

  // Wrapping increment of a requester index.
  function automatic logic [2:0] f_next(input logic [2:0] idx);
    return (idx == c_LAST) ? 3'd0 : idx + 3'd1;
  endfunction

  // Zero-extend the request buses so any 3-bit index selects in range.
  assign w_valid_ext = 8'(req_valid);
  assign w_data_ext  = 32'(req_data);
  assign w_cfg_ext   = 64'(req_cfg);
  assign w_free      = {r_state[1] == S_IDLE, r_state[0] == S_IDLE};
  assign w_done      = {w1_x2, w0_x2};

  // Find the first and second valid requesters starting from the RR pointer.
  always_comb begin : arb_search
    logic [2:0] scan;
    w_g1_found = 1'b0;
    w_g1_idx   = r_ptr;
    w_g2_found = 1'b0;
    w_g2_idx   = r_ptr;
    scan       = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_g1_found && w_valid_ext[scan]) begin
        w_g1_found = 1'b1;
        w_g1_idx   = scan;
      end
      scan = f_next(scan);
    end
    scan = f_next(w_g1_idx);
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      if (!w_g2_found && w_valid_ext[scan]) begin
        w_g2_found = 1'b1;
        w_g2_idx   = scan;
      end
      scan = f_next(scan);
    end
  end

  // Map grants onto free lanes (lane0 first); the second grant needs both lanes free.
  always_comb begin
    w_grant1     = w_g1_found && (w_free != 2'b00);
    w_grant2     = w_grant1 && w_g2_found && (w_free == 2'b11);
    w_accept     = 2'b00;
    w_acc_idx[0] = w_g1_idx;
    w_acc_idx[1] = w_g1_idx;
    w_ptr_nxt    = r_ptr;
    if (w_grant1) begin
      w_ptr_nxt = f_next(w_g1_idx);
      if (w_free[0]) begin
        w_accept[0] = 1'b1;
      end else begin
        w_accept[1] = 1'b1;
      end
    end
    if (w_grant2) begin
      w_accept[1]  = 1'b1;
      w_acc_idx[1] = w_g2_idx;
      w_ptr_nxt    = f_next(w_g2_idx);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n &&
                     ((w_grant1 && (w_g1_idx == 3'(i))) ||
                      (w_grant2 && (w_g2_idx == 3'(i))));
    end
  end

  // Per-lane next state: issue for one cycle, then wait for done or timeout.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_state_nxt[n]     = r_state[n];
      w_cnt_nxt[n]       = r_cnt[n];
      w_rsp_valid_nxt[n] = 1'b0;
      w_rsp_err_nxt[n]   = 1'b0;
      case (r_state[n])
        S_IDLE: begin
          if (w_accept[n]) begin
            w_state_nxt[n] = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_state_nxt[n] = S_WAIT;
          w_cnt_nxt[n]   = 8'd0;
        end
        S_WAIT: begin
          // Done takes priority over a timeout in the same cycle.
          if (w_done[n]) begin
            w_state_nxt[n]     = S_IDLE;
            w_rsp_valid_nxt[n] = 1'b1;
          end else if (({1'b0, r_cnt[n]} + 9'd1) == c_TIMEOUT) begin
            w_state_nxt[n]     = S_IDLE;
            w_rsp_valid_nxt[n] = 1'b1;
            w_rsp_err_nxt[n]   = 1'b1;
          end else begin
            w_cnt_nxt[n] = r_cnt[n] + 8'd1;
          end
        end
        default: begin
          w_state_nxt[n] = S_IDLE;
        end
      endcase
    end
  end

  // Lane state, timeout counter, response pulse and latched job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        r_state[n]     <= S_IDLE;
        r_cnt[n]       <= 8'd0;
        r_rsp_valid[n] <= 1'b0;
        r_rsp_err[n]   <= 1'b0;
        r_cfg[n]       <= 8'd0;
        r_data[n]      <= 4'd0;
        r_id[n]        <= 3'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_state[n]     <= w_state_nxt[n];
        r_cnt[n]       <= w_cnt_nxt[n];
        r_rsp_valid[n] <= w_rsp_valid_nxt[n];
        r_rsp_err[n]   <= w_rsp_err_nxt[n];
        if (w_accept[n]) begin
          r_cfg[n]  <= w_cfg_ext[{w_acc_idx[n], 3'b000} +: 8];
          r_data[n] <= w_data_ext[{w_acc_idx[n], 2'b00} +: 4];
          r_id[n]   <= w_acc_idx[n];
        end
      end
    end
  end

  // Round-robin pointer advances past the last granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign w0_C       = r_cfg[0];
  assign w0_x1      = r_data[0];
  assign w0_x0      = (r_state[0] == S_ISSUE);
  assign w1_C       = r_cfg[1];
  assign w1_x1      = r_data[1];
  assign w1_x0      = (r_state[1] == S_ISSUE);
  assign rsp0_valid = r_rsp_valid[0];
  assign rsp0_err   = r_rsp_err[0];
  assign rsp0_id    = r_id[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp1_err   = r_rsp_err[1];
  assign rsp1_id    = r_id[1];
  assign busy       = (w_free != 2'b11);

endmodule
`default_nettype wire
